// File: rtl/scalar_writeback_pkg.sv
// Shared types and defaults for the scalar writeback stage.
package scalar_pkg;
  localparam int DATA_WIDTH   = 8;
  localparam int NUM_REGS     = 8;
  localparam int REG_ADDR_W   = $clog2(NUM_REGS);
  localparam int STARVE_LIMIT = 3;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } wb_hold_state_e;
endpackage

// File: rtl/scalar_writeback_if.sv
// Bundle of ALU / load / issue inputs and register-file / scoreboard outputs.
// SCALAR_WB_BYPASS_EN adds the one-cycle-early forwarding signals.
interface scalar_writeback_if #(
  parameter int DATA_WIDTH = scalar_pkg::DATA_WIDTH,
  parameter int NUM_REGS   = scalar_pkg::NUM_REGS,
  parameter int REG_ADDR_W = $clog2(NUM_REGS)
);
  logic                  aluValid;
  logic [REG_ADDR_W-1:0] aluRd;
  logic [DATA_WIDTH-1:0] aluData;
  logic                  memValid;
  logic [REG_ADDR_W-1:0] memRd;
  logic [DATA_WIDTH-1:0] memData;
  logic                  memReady;
  logic                  issueValid;
  logic [REG_ADDR_W-1:0] issueRd;
  logic                  regWrEn;
  logic [REG_ADDR_W-1:0] regToWrite;
  logic [DATA_WIDTH-1:0] wbData;
  logic [NUM_REGS-1:0]   pendingMask;
  logic                  aluStall;
`ifdef SCALAR_WB_BYPASS_EN
  logic                  bypassValid;
  logic [REG_ADDR_W-1:0] bypassRd;
  logic [DATA_WIDTH-1:0] bypassData;

  modport slave (
    input  aluValid, aluRd, aluData, memValid, memRd, memData, issueValid, issueRd,
    output memReady, regWrEn, regToWrite, wbData, pendingMask, aluStall,
           bypassValid, bypassRd, bypassData
  );
  modport master (
    output aluValid, aluRd, aluData, memValid, memRd, memData, issueValid, issueRd,
    input  memReady, regWrEn, regToWrite, wbData, pendingMask, aluStall,
           bypassValid, bypassRd, bypassData
  );
`else
  modport slave (
    input  aluValid, aluRd, aluData, memValid, memRd, memData, issueValid, issueRd,
    output memReady, regWrEn, regToWrite, wbData, pendingMask, aluStall
  );
  modport master (
    output aluValid, aluRd, aluData, memValid, memRd, memData, issueValid, issueRd,
    input  memReady, regWrEn, regToWrite, wbData, pendingMask, aluStall
  );
`endif
endinterface

// File: rtl/scalar_writeback_hold_reg.sv
// One-entry holding register for a load displaced by the ALU, with the
// starve counter that drives the ALU stall request.
module wb_hold_reg #(
  parameter int STARVE_LIMIT = scalar_pkg::STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic                  mem_valid,
  input  scalar_pkg::wb_entry_t mem_entry,
  output logic                  mem_ready,
  output logic                  load_commit,
  output scalar_pkg::wb_entry_t load_entry,
  output logic                  stall
);
  import scalar_pkg::*;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  wb_hold_state_e   state_q, state_d;
  wb_entry_t        held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    cnt_d       = cnt_q;
    mem_ready   = 1'b0;
    load_commit = 1'b0;
    load_entry  = held_q;
    case (state_q)
      EMPTY: begin
        // ready depends on state only, so the load side never sees a comb loop
        mem_ready  = 1'b1;
        cnt_d      = '0;
        load_entry = mem_entry;
        if (mem_valid) begin
          if (alu_valid) begin
            held_d  = mem_entry;
            state_d = HELD;
          end else begin
            load_commit = 1'b1;
          end
        end
      end
      HELD: begin
        if (!alu_valid) begin
          load_commit = 1'b1;
          state_d     = EMPTY;
          cnt_d       = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall = (cnt_q == CNT_MAX);
endmodule

// File: rtl/scalar_writeback.sv
// Scalar writeback: ALU-priority merge of ALU and load results into the
// register-file write port, plus the pending-load scoreboard.
// SCALAR_WB_BYPASS_EN exposes next-cycle write values for decode forwarding.
module scalar_writeback #(
  parameter int DATA_WIDTH   = scalar_pkg::DATA_WIDTH,
  parameter int NUM_REGS     = scalar_pkg::NUM_REGS,
  parameter int REG_ADDR_W   = $clog2(NUM_REGS),
  parameter int STARVE_LIMIT = scalar_pkg::STARVE_LIMIT
) (
  input logic              clk,
  input logic              reset,
  scalar_writeback_if.slave bus
);
  import scalar_pkg::*;

  wb_entry_t             mem_entry, load_entry;
  logic                  load_commit, mem_ready, stall;
  logic                  wr_en_d, wr_en_q;
  logic [REG_ADDR_W-1:0] wr_rd_d, wr_rd_q;
  logic [DATA_WIDTH-1:0] wr_data_d, wr_data_q;
  logic [NUM_REGS-1:0]   pend_d, pend_q;

  assign mem_entry = '{rd: bus.memRd, data: bus.memData};

  wb_hold_reg #(.STARVE_LIMIT(STARVE_LIMIT)) u_hold (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (bus.aluValid),
    .mem_valid   (bus.memValid),
    .mem_entry   (mem_entry),
    .mem_ready   (mem_ready),
    .load_commit (load_commit),
    .load_entry  (load_entry),
    .stall       (stall)
  );

  // ALU always wins the single write port; the hold register absorbs the loser
  always_comb begin
    wr_en_d   = 1'b0;
    wr_rd_d   = '0;
    wr_data_d = '0;
    if (bus.aluValid) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = bus.aluRd;
      wr_data_d = bus.aluData;
    end else if (load_commit) begin
      wr_en_d   = 1'b1;
      wr_rd_d   = load_entry.rd;
      wr_data_d = load_entry.data;
    end
  end

  // a new issue to the same register must stay pending over the old commit
  always_comb begin
    pend_d = pend_q;
    if (load_commit)    pend_d[load_entry.rd] = 1'b0;
    if (bus.issueValid) pend_d[bus.issueRd]   = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
      pend_q    <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
    end
  end

  assign bus.memReady    = mem_ready;
  assign bus.regWrEn     = wr_en_q;
  assign bus.regToWrite  = wr_rd_q;
  assign bus.wbData      = wr_data_q;
  assign bus.pendingMask = pend_q;
  assign bus.aluStall    = stall;

`ifdef SCALAR_WB_BYPASS_EN
  assign bus.bypassValid = wr_en_d;
  assign bus.bypassRd    = wr_rd_d;
  assign bus.bypassData  = wr_data_d;
`endif
endmodule

// File: tb/tb_scalar_writeback.sv
// Self-checking bench for scalar_writeback: vector table plus reset corner cases.
module tb_scalar_writeback;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scalar_writeback_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW)) bus ();

  scalar_writeback #(.DATA_WIDTH(DW), .NUM_REGS(NR), .REG_ADDR_W(AW), .STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic av; logic [AW-1:0] ard; logic [DW-1:0] adat;
    logic mv; logic [AW-1:0] mrd; logic [DW-1:0] mdat;
    logic iv; logic [AW-1:0] ird;
    logic en; logic [AW-1:0] rd;  logic [DW-1:0] data;
    logic [NR-1:0] mask; logic ready; logic stall;
  } vec_t;

  typedef struct { logic en; logic [AW-1:0] rd; logic [DW-1:0] data; } wr_t;

  wr_t        exp_q[$];
  vec_t       vecs[$];
  int         checks = 0;
  int         errors = 0;
  logic [DW-1:0] rf [NR];

  // register file model fed by the DUT write port
  initial for (int i = 0; i < NR; i++) rf[i] = '0;
  always @(posedge clk) if (bus.regWrEn) rf[bus.regToWrite] <= bus.wbData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic av, logic [AW-1:0] ard, logic [DW-1:0] adat,
                              logic mv, logic [AW-1:0] mrd, logic [DW-1:0] mdat,
                              logic iv, logic [AW-1:0] ird,
                              logic en, logic [AW-1:0] rd, logic [DW-1:0] data,
                              logic [NR-1:0] mask, logic ready, logic stall);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.iv = iv; v.ird = ird;
    v.en = en; v.rd = rd; v.data = data;
    v.mask = mask; v.ready = ready; v.stall = stall;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                       input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdat,
                       input logic iv, input logic [AW-1:0] ird);
    bus.aluValid = av; bus.aluRd = ard; bus.aluData = adat;
    bus.memValid = mv; bus.memRd = mrd; bus.memData = mdat;
    bus.issueValid = iv; bus.issueRd = ird;
  endtask

  task automatic check_write(input string tag);
    wr_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " regWrEn"}, bus.regWrEn, e.en);
    if (e.en) begin
      chk({tag, " regToWrite"}, bus.regToWrite, e.rd);
      chk({tag, " wbData"}, bus.wbData, e.data);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " regWrEn"}, bus.regWrEn, 0);
    chk({tag, " regToWrite"}, bus.regToWrite, 0);
    chk({tag, " wbData"}, bus.wbData, 0);
    chk({tag, " pendingMask"}, bus.pendingMask, 0);
    chk({tag, " aluStall"}, bus.aluStall, 0);
    chk({tag, " memReady"}, bus.memReady, 1);
  endtask

  initial begin
    wr_t w;
    // inputs | expected outputs after the edge that samples them
    //       av ard adat   mv mrd mdat   iv ird  en rd data   mask  rdy stl
    vecs.push_back(mk(1, 1, 8'hFE, 0, 0, 8'h00, 0, 0, 1, 1, 8'hFE, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 7, 0, 0, 8'h00, 8'h80, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h80, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 7, 8'hFA, 0, 0, 1, 7, 8'hFA, 8'h00, 1, 0));
    vecs.push_back(mk(1, 2, 8'h11, 1, 3, 8'h22, 0, 0, 1, 2, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 3, 8'h22, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 0, 0, 8'h00, 8'h10, 1, 0));
    vecs.push_back(mk(1, 0, 8'hA0, 1, 4, 8'h44, 0, 0, 1, 0, 8'hA0, 8'h10, 0, 0));
    vecs.push_back(mk(1, 0, 8'hA1, 0, 0, 8'h00, 0, 0, 1, 0, 8'hA1, 8'h10, 0, 0));
    vecs.push_back(mk(1, 0, 8'hA2, 0, 0, 8'h00, 0, 0, 1, 0, 8'hA2, 8'h10, 0, 0));
    vecs.push_back(mk(1, 0, 8'hA3, 0, 0, 8'h00, 0, 0, 1, 0, 8'hA3, 8'h10, 0, 1));
    vecs.push_back(mk(1, 0, 8'hA4, 0, 0, 8'h00, 0, 0, 1, 0, 8'hA4, 8'h10, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 4, 8'h44, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 0, 0, 8'h00, 8'h20, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 5, 8'h55, 1, 5, 1, 5, 8'h55, 8'h20, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 5, 8'h56, 0, 0, 1, 5, 8'h56, 8'h00, 1, 0));
    vecs.push_back(mk(1, 6, 8'h66, 1, 6, 8'h77, 0, 0, 1, 6, 8'h66, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 6, 8'h88, 0, 0, 1, 6, 8'h77, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 6, 8'h88, 0, 0, 1, 6, 8'h88, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0));

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat,
            vecs[i].iv, vecs[i].ird);
      w.en = vecs[i].en; w.rd = vecs[i].rd; w.data = vecs[i].data;
      exp_q.push_back(w);
`ifdef SCALAR_WB_BYPASS_EN
      #1;
      chk($sformatf("vec%0d bypassValid", i), bus.bypassValid, vecs[i].en);
      if (vecs[i].en) begin
        chk($sformatf("vec%0d bypassRd", i), bus.bypassRd, vecs[i].rd);
        chk($sformatf("vec%0d bypassData", i), bus.bypassData, vecs[i].data);
      end
`endif
      @(posedge clk);
      #1;
      check_write($sformatf("vec%0d", i));
      chk($sformatf("vec%0d pendingMask", i), bus.pendingMask, vecs[i].mask);
      chk($sformatf("vec%0d memReady", i), bus.memReady, vecs[i].ready);
      chk($sformatf("vec%0d aluStall", i), bus.aluStall, vecs[i].stall);
    end

    chk("rf[1]", rf[1], 8'hFE);
    chk("rf[7]", rf[7], 8'hFA);
    chk("rf[2]", rf[2], 8'h11);
    chk("rf[3]", rf[3], 8'h22);
    chk("rf[0]", rf[0], 8'hA4);
    chk("rf[4]", rf[4], 8'h44);
    chk("rf[5]", rf[5], 8'h56);
    chk("rf[6]", rf[6], 8'h88);

    // reset while a load sits in the holding register
    drive(1, 2, 8'hBB, 1, 3, 8'hCC, 1, 3);
    w.en = 1'b1; w.rd = 2; w.data = 8'hBB;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    check_write("held0");
    chk("held0 pendingMask", bus.pendingMask, 8'h08);
    chk("held0 memReady", bus.memReady, 0);
    drive(1, 2, 8'hBC, 0, 0, 0, 0, 0);
    w.en = 1'b1; w.rd = 2; w.data = 8'hBC;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
    check_write("held1");
    chk("held1 memReady", bus.memReady, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    check_reset_vals("reset_hold");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w.en = 1'b0; w.rd = 0; w.data = 0;
      exp_q.push_back(w);
      @(posedge clk);
      #1;
      check_write($sformatf("post_reset%0d", k));
      chk($sformatf("post_reset%0d memReady", k), bus.memReady, 1);
    end
    chk("post_reset pendingMask", bus.pendingMask, 0);
    chk("held data never written", rf[3], 8'h22);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/scalar_writeback.md
# scalar_writeback

Writeback stage that feeds the scalar register file's write port (`regWrEn`, `regToWrite`, data-in). It merges single-cycle results from the scalar ALU with variable-latency results from the load unit, which uses a valid/ready handshake. The ALU has priority, and a load displaced by the ALU is held in a one-entry holding register. A per-register pending-load scoreboard is kept for the decode/hazard logic.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of scalar data.
- `NUM_REGS`, 8, number of scalar registers.
- `REG_ADDR_W`, `$clog2(NUM_REGS)`, register index width.
- `STARVE_LIMIT`, 3, number of consecutive cycles a held load may lose to the ALU before a stall is requested.

Ports:
- `clk` in 1: the only clock; all state is updated on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `aluValid` in 1: ALU result present; it is always accepted.
- `aluRd` in `REG_ADDR_W`: ALU destination register.
- `aluData` in `DATA_WIDTH`: ALU result.
- `memValid` in 1: load result offered.
- `memRd` in `REG_ADDR_W`: load destination register.
- `memData` in `DATA_WIDTH`: load data.
- `memReady` out 1: load result accepted when `memValid && memReady`.
- `issueValid` in 1: decode issued a load this cycle.
- `issueRd` in `REG_ADDR_W`: destination of the issued load.
- `regWrEn` out 1: register file write enable.
- `regToWrite` out `REG_ADDR_W`: register file write index.
- `wbData` out `DATA_WIDTH`: register file write data (connects to the register file's data-in).
- `pendingMask` out `NUM_REGS`: bit r = 1 means a load to register r is outstanding.
- `aluStall` out 1: request to upstream to suppress the ALU result next cycle.

## Operation
Holding FSM states:
- **EMPTY**: `memReady` = 1.
  - `aluValid` and a load handshake in the same cycle: the ALU result is committed; the load is captured into the holding register; go to HELD.
  - Only a load handshake: the load is committed directly; stay in EMPTY.
- **HELD**: `memReady` = 0.
  - `aluValid` = 0: the held load is committed; go to EMPTY.
  - `aluValid` = 1: the ALU result is committed and the held load stays; starve counter increments, saturating at `STARVE_LIMIT`.

Starve counter and stall:
- The starve counter clears on entry to EMPTY.
- `aluStall` = 1 while the counter equals `STARVE_LIMIT`.
- If the ALU sends anyway while stalled, the ALU result still wins. No data is ever dropped.

Scoreboard:
- `issueValid` sets `pendingMask[issueRd]`.
- Committing a load clears `pendingMask[rd]` for that load's destination.
- Set and clear of the same register in the same cycle: set wins.
- An ALU commit does not alter `pendingMask`.
- Writes to any register index are allowed; there is no hardwired zero register.

## Timing
- Reset value of every output:
  - `regWrEn`, `regToWrite`, `wbData`, `pendingMask`, `aluStall` are all 0.
  - `memReady` = 1.
  - FSM in EMPTY, counter = 0.
- `regWrEn`, `regToWrite` and `wbData` are registered. An input accepted at edge T appears on these outputs for exactly the cycle after T.
  - The register file writes at edge T+1.
  - A result is visible on the register file's read port after edge T+1.
- Per-path latency:
  - ALU: always 1 cycle.
  - Load in EMPTY: 1 cycle.
  - Load in HELD: 1 + number of ALU cycles that beat it.
- `memReady` is a combinational function of the FSM state only, never of `memValid`.
- `pendingMask` and `aluStall` are registered.
- At most one register file write per cycle.
- Reset asserted mid-operation: the held load is discarded, `pendingMask` is cleared, and no write is issued.

## Configuration
`SCALAR_WB_BYPASS_EN`:
- **Defined**: adds outputs `bypassValid`, `bypassRd` and `bypassData`. These are combinational and show the value that `regWrEn`/`regToWrite`/`wbData` will carry next cycle, so decode can forward a result one cycle before the register file holds it.
- **Undefined**: these ports do not exist and no forwarding logic is built.

## Structure
- Shared package `scalar_pkg`:
  - `DATA_WIDTH`, `NUM_REGS`, `REG_ADDR_W` defaults.
  - `wb_entry_t` struct {rd, data}.
  - FSM enum `wb_hold_state_e` {EMPTY, HELD}.
- One sub-module, `wb_hold_reg`: the one-entry holding register with the valid/ready handshake and the starve counter.
- The scoreboard is inline.

## Test plan
- Reset, then `aluValid`, `aluRd`=1, `aluData`=8'hFE: `regWrEn`=1, `regToWrite`=1, `wbData`=FE in the next cycle; the register file reads FE one cycle after that.
- `issueValid` with `issueRd`=7, then a load handshake with rd=7, data=FA: `pendingMask`=8'h80 until commit, then 0; `wbData`=FA.
- ALU (rd 2, 11) and load (rd 3, 22) valid in the same cycle:
  - Write 2/11 first, then 3/22.
  - `memReady`=0 for one cycle.
- Load held while `aluValid`=1 for 4 cycles: `aluStall` rises after 3 losses; after `aluValid` drops, the load commits and `aluStall` clears.
- `issueValid` for rd 5 in the same cycle as the commit of a load to rd 5: `pendingMask[5]` stays 1.
- `reset` pulsed while in HELD:
  - All outputs return to reset values and `memReady`=1.
  - The held data is never written.
